// File: rtl/dmem_responder.sv
// Data-memory responder: clear-on-reset sweep, registered 1-cycle reads, saturating write counter.
// Optional macro DMEM_RESP_FWD_EN: same-address read-during-write returns the new data instead of the old.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WCOUNT_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    wren,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    ready,
    output logic [WCOUNT_WIDTH-1:0] write_count
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_ptr_q, init_ptr_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic                    ready_q, ready_d;
    logic [WCOUNT_WIDTH-1:0] write_count_q, write_count_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        q_d           = q_q;
        ready_d       = ready_q;
        write_count_d = write_count_q;
        mem_we        = 1'b0;
        mem_waddr     = address;
        mem_wdata     = data;
        case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = '0;
                init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
                q_d        = '0;
                if (init_ptr_q == '1) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                mem_we = wren;
                // q_d samples the array before this edge's write lands, giving read-first order
                q_d    = mem[address];
`ifdef DMEM_RESP_FWD_EN
                if (wren) q_d = data;
`endif
                if (wren && write_count_q != '1)
                    write_count_d = write_count_q + WCOUNT_WIDTH'(1);
            end
        endcase
        // A write presented on a reset edge is discarded
        if (!reset) mem_we = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= INIT;
            init_ptr_q    <= '0;
            q_q           <= '0;
            ready_q       <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            q_q           <= q_d;
            ready_q       <= ready_d;
            write_count_q <= write_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign q           = q_q;
    assign ready       = ready_q;
    assign write_count = write_count_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the processor's data-memory port: accepts the processor's address/data/write-enable requests and returns read data one clock later. Sits between the processor and the DMEM slot of the top level, and can stand in for the generated syncram. Adds a hardware clear-on-reset sweep, a `ready` flag and a saturating write counter so the processor and the bench can tell when memory contents are defined.

## Interface
Parameters:
- ADDR_WIDTH, 12, word-address width; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 32, word width
- WCOUNT_WIDTH, 16, width of the saturating write counter

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of `clock`
- address  in  ADDR_WIDTH  word address from the processor
- data  in  DATA_WIDTH  write data from the processor
- wren  in  1  write enable; active high
- q  out  DATA_WIDTH  registered read data
- ready  out  1  high once the clear sweep has finished
- write_count  out  WCOUNT_WIDTH  number of accepted writes since reset, saturating

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH array.
- The FSM has two states.
  - INIT (reset state): each cycle writes 0 to mem[init_ptr], then sets init_ptr <= init_ptr + 1.
  - INIT ignores `wren`, `address` and `data` entirely. No write is accepted and no count is taken.
  - When init_ptr == 2^ADDR_WIDTH − 1, that last word is cleared and the FSM moves to RUN. init_ptr wraps to 0.
  - RUN: every cycle, q <= mem[address].
  - RUN with wren = 1: mem[address] <= data, and write_count increments.
  - write_count stops at 2^WCOUNT_WIDTH − 1 (all ones). It does not wrap.
  - RUN never returns to INIT except via reset.
- Read-during-write to the same address: q returns the old contents (read-first) unless DMEM_RESP_FWD_EN is defined (see Configuration).
- Addresses are full width, so there is no out-of-range case.
- X or Z on `wren` while in RUN is a protocol error. The bench flags it; no RTL handling is required.

## Timing
- Reset values while `reset` is low at an edge:
  - state = INIT, init_ptr = 0
  - q = 0, ready = 0, write_count = 0
- Memory contents are not reset directly; the sweep clears them.
- Clear sweep takes exactly 2^ADDR_WIDTH cycles after the first edge with `reset` high.
  - `ready` rises on the edge that completes the last clear: the 4096th edge for ADDR_WIDTH = 12.
  - The first request accepted is the one presented in the cycle where `ready` is first seen high.
- Read latency is 1 cycle: an address sampled at edge N gives q valid after edge N, stable until edge N+1.
- q holds 0 throughout INIT.
- Write latency: data sampled at edge N is readable by an address presented at edge N+1.
- write_count updates on the same edge as the write.
- Reset asserted mid-sweep or mid-RUN:
  - the next edge returns to INIT with init_ptr = 0, q = 0, ready = 0, write_count = 0;
  - the sweep restarts from word 0;
  - a write presented on that same edge is discarded.
- Back-to-back writes and reads are supported every cycle, with no stalls in RUN.

## Configuration
- DMEM_RESP_FWD_EN defined: a same-cycle wren = 1 and read of the same address gives q = data (write-first / forwarding).
- DMEM_RESP_FWD_EN undefined: the same case gives q = the previous mem[address] (read-first, matching the syncram default).
- All other behaviour is identical in both builds.

## Test plan
- Sweep:
  - Stimulus: reset low for 2 cycles, then high, with the RAM pre-loaded to nonzero values in the bench.
  - Response: ready = 0 for 4095 edges and 1 at edge 4096. A subsequent read of addresses 0x000, 0x7FF and 0xFFF gives q = 0 one cycle later.
- Basic R/W:
  - Stimulus: write 0xDEADBEEF to 0x123, then read 0x123.
  - Response: q = 0xDEADBEEF after the read edge; write_count = 1.
- Read-during-write:
  - Stimulus: after writing 0x11111111 to 0x040, present wren = 1, address = 0x040, data = 0x22222222.
  - Response: q = 0x11111111 without the macro; q = 0x22222222 with DMEM_RESP_FWD_EN. A following read returns 0x22222222 in both builds.
- Writes during INIT ignored:
  - Stimulus: drive wren = 1, address = 0x010, data = 0xFFFFFFFF throughout the sweep.
  - Response: after ready, a read of 0x010 gives 0 and write_count = 0.
- Reset mid-operation:
  - Stimulus: in RUN, write 0xA5A5A5A5 to 0x200, then pulse reset low for 1 cycle at sweep step 100 of a second run.
  - Response: ready drops next edge and the sweep restarts from 0. After 4096 further edges, a read of 0x200 gives 0 and write_count = 0.
- Counter saturation:
  - Stimulus: with WCOUNT_WIDTH = 4, issue 20 consecutive writes.
  - Response: write_count reaches 15 and stays 15; all 20 writes still land in memory.
